// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: RV32I(M) ID-stage decode, ID/EX register, hazard, flush and divide-stall control
module pipe_ctrl_unit #(
    parameter int M_EXT   = 0,
    parameter int DIV_LAT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_inst,
    input  logic        i_inst_vld,
    input  logic        i_br_equal,
    input  logic        i_br_less,
    output logic        o_stall,
    output logic        o_flush,
    output logic        o_pc_sel,
    output logic        o_ex_busy,
    output logic        o_ex_vld,
    output logic        o_ex_insn_vld,
    output logic [2:0]  o_ex_imm_sel,
    output logic [2:0]  o_ex_load_type,
    output logic [2:0]  o_ex_slt_sl,
    output logic        o_ex_rd_wren,
    output logic        o_ex_wren,
    output logic        o_ex_asel,
    output logic        o_ex_bsel,
    output logic        o_ex_br_un,
    output logic [4:0]  o_ex_alu_op,
    output logic [1:0]  o_ex_wb_sel,
    output logic [4:0]  o_ex_rd,
    output logic [4:0]  o_ex_rs1,
    output logic [4:0]  o_ex_rs2
);
    localparam int CW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV_LAT - 1);
    typedef struct packed {
        logic       vld;
        logic       insn_vld;
        logic [2:0] imm_sel;
        logic [2:0] load_type;
        logic [2:0] slt_sl;
        logic       rd_wren;
        logic       wren;
        logic       asel;
        logic       bsel;
        logic       br_un;
        logic [4:0] alu_op;
        logic [1:0] wb_sel;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       jmp;
        logic       br;
        logic [2:0] f3;
        logic       load;
        logic       div;
    } ex_t;
    ex_t r_ex, w_dec;
    logic [CW-1:0] r_cnt;
    logic [6:0] w_op, w_f7;
    logic [2:0] w_f3;
    logic w_r, w_i, w_ld, w_st, w_br, w_jal, w_jalr, w_lui, w_aui;
    logic w_f7_z, w_f7_alt, w_mop, w_legal, w_use1, w_use2;
    logic w_lu, w_taken, w_pc, w_busy;
    assign w_op     = i_inst[6:0];
    assign w_f3     = i_inst[14:12];
    assign w_f7     = i_inst[31:25];
    assign w_r      = w_op == 7'b0110011;
    assign w_i      = w_op == 7'b0010011;
    assign w_ld     = w_op == 7'b0000011;
    assign w_st     = w_op == 7'b0100011;
    assign w_br     = w_op == 7'b1100011;
    assign w_jal    = w_op == 7'b1101111;
    assign w_jalr   = w_op == 7'b1100111;
    assign w_lui    = w_op == 7'b0110111;
    assign w_aui    = w_op == 7'b0010111;
    assign w_f7_z   = w_f7 == 7'b0000000;
    assign w_f7_alt = w_f7 == 7'b0100000;
    assign w_mop    = (M_EXT != 0) & w_r & (w_f7 == 7'b0000001);
    assign w_legal  = (w_r & (w_f7_z | (w_f7_alt & (w_f3 == 3'd0 | w_f3 == 3'd5)) | w_mop))
                    | (w_i & (w_f3 == 3'd1 ? w_f7_z : w_f3 == 3'd5 ? (w_f7_z | w_f7_alt) : 1'b1))
                    | (w_ld & w_f3 != 3'd3 & w_f3 < 3'd6) | (w_st & w_f3 < 3'd3)
                    | (w_br & w_f3[2:1] != 2'b01) | w_jal | (w_jalr & w_f3 == 3'd0) | w_lui | w_aui;
    always_comb begin
        w_dec           = '0;
        w_dec.vld       = 1'b1;
        w_dec.insn_vld  = w_legal;
        w_dec.imm_sel   = w_st ? 3'd1 : w_br ? 3'd2 : w_jal ? 3'd3 : w_lui ? 3'd4 : w_aui ? 3'd5 : 3'd0;
        w_dec.load_type = w_ld ? w_f3 : 3'd0;
        w_dec.slt_sl    = w_st ? w_f3 : 3'd0;
        w_dec.rd_wren   = w_legal & (w_r | w_i | w_ld | w_jal | w_jalr | w_lui | w_aui);
        w_dec.wren      = w_legal & w_st;
        w_dec.asel      = w_br | w_jal | w_aui;
        w_dec.bsel      = ~w_r;
        w_dec.br_un     = w_br & w_f3[1];
        w_dec.alu_op    = w_mop ? {2'b10, w_f3} : w_r ? {1'b0, w_f7[5], w_f3}
                        : w_i ? {1'b0, w_f3 == 3'd5 & w_f7[5], w_f3} : w_lui ? 5'b01111 : 5'b00000;
        w_dec.wb_sel    = w_ld ? 2'b00 : (w_jal | w_jalr) ? 2'b10 : 2'b01;
        w_dec.rd        = i_inst[11:7];
        w_dec.rs1       = i_inst[19:15];
        w_dec.rs2       = i_inst[24:20];
        w_dec.jmp       = w_legal & (w_jal | w_jalr);
        w_dec.br        = w_legal & w_br;
        w_dec.f3        = w_f3;
        w_dec.load      = w_legal & w_ld;
        w_dec.div       = w_legal & w_mop & w_f3[2];
    end
    assign w_use1  = w_r | w_i | w_ld | w_st | w_br | w_jalr;
    assign w_use2  = w_r | w_st | w_br;
    assign w_lu    = i_inst_vld & r_ex.vld & r_ex.load & (r_ex.rd != 5'd0)
                   & ((w_use1 & w_dec.rs1 == r_ex.rd) | (w_use2 & w_dec.rs2 == r_ex.rd));
    // funct3[0] inverts the sense: BNE/BGE/BGEU
    assign w_taken = r_ex.jmp | (r_ex.br & ((r_ex.f3[2] ? i_br_less : i_br_equal) ^ r_ex.f3[0]));
    assign w_pc    = ~i_reset & r_ex.vld & r_ex.insn_vld & w_taken;
    assign w_busy  = ~i_reset & r_ex.vld & r_ex.div & (r_cnt < LAST);
    assign o_pc_sel  = w_pc;
    assign o_flush   = w_pc;
    assign o_ex_busy = w_busy;
    assign o_stall   = ~i_reset & ~w_pc & (w_busy | w_lu);
    always_ff @(posedge i_clk) begin
        if (i_reset | w_pc) begin
            r_ex  <= '0;
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_ex  <= (w_lu | ~i_inst_vld) ? '0 : w_dec;
            r_cnt <= '0;
        end
    end
    assign o_ex_vld       = r_ex.vld;
    assign o_ex_insn_vld  = r_ex.insn_vld;
    assign o_ex_imm_sel   = r_ex.imm_sel;
    assign o_ex_load_type = r_ex.load_type;
    assign o_ex_slt_sl    = r_ex.slt_sl;
    assign o_ex_rd_wren   = r_ex.rd_wren;
    assign o_ex_wren      = r_ex.wren;
    assign o_ex_asel      = r_ex.asel;
    assign o_ex_bsel      = r_ex.bsel;
    assign o_ex_br_un     = r_ex.br_un;
    assign o_ex_alu_op    = r_ex.alu_op;
    assign o_ex_wb_sel    = r_ex.wb_sel;
    assign o_ex_rd        = r_ex.rd;
    assign o_ex_rs1       = r_ex.rs1;
    assign o_ex_rs2       = r_ex.rs2;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed and random checks of pipe_ctrl_unit against an instruction-level model
module tb_pipe_ctrl_unit;
    localparam int DL = 4;
    typedef struct packed {
        logic       legal;
        logic [2:0] imm, ld, st;
        logic       rdw, wr, asel, bsel, bun;
        logic [4:0] alu;
        logic [1:0] wb;
        logic [4:0] rd, rs1, rs2;
    } ctl_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, vld, eq, lt;
    logic [31:0] inst;
    logic o_stall, o_flush, o_pc_sel, o_ex_busy, o_ex_vld, o_ex_insn_vld;
    logic [2:0] o_ex_imm_sel, o_ex_load_type, o_ex_slt_sl;
    logic o_ex_rd_wren, o_ex_wren, o_ex_asel, o_ex_bsel, o_ex_br_un;
    logic [4:0] o_ex_alu_op, o_ex_rd, o_ex_rs1, o_ex_rs2;
    logic [1:0] o_ex_wb_sel;
    logic z_stall, z_flush, z_pc_sel, z_ex_busy, z_ex_vld, z_ex_insn_vld;
    logic [2:0] z_ex_imm_sel, z_ex_load_type, z_ex_slt_sl;
    logic z_ex_rd_wren, z_ex_wren, z_ex_asel, z_ex_bsel, z_ex_br_un;
    logic [4:0] z_ex_alu_op, z_ex_rd, z_ex_rs1, z_ex_rs2;
    logic [1:0] z_ex_wb_sel;
    pipe_ctrl_unit #(.M_EXT(1), .DIV_LAT(DL)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_inst(inst), .i_inst_vld(vld), .i_br_equal(eq), .i_br_less(lt),
        .o_stall(o_stall), .o_flush(o_flush), .o_pc_sel(o_pc_sel), .o_ex_busy(o_ex_busy),
        .o_ex_vld(o_ex_vld), .o_ex_insn_vld(o_ex_insn_vld), .o_ex_imm_sel(o_ex_imm_sel),
        .o_ex_load_type(o_ex_load_type), .o_ex_slt_sl(o_ex_slt_sl), .o_ex_rd_wren(o_ex_rd_wren),
        .o_ex_wren(o_ex_wren), .o_ex_asel(o_ex_asel), .o_ex_bsel(o_ex_bsel), .o_ex_br_un(o_ex_br_un),
        .o_ex_alu_op(o_ex_alu_op), .o_ex_wb_sel(o_ex_wb_sel), .o_ex_rd(o_ex_rd), .o_ex_rs1(o_ex_rs1),
        .o_ex_rs2(o_ex_rs2)
    );
    pipe_ctrl_unit #(.M_EXT(0), .DIV_LAT(DL)) u_m0 (
        .i_clk(clk), .i_reset(rst), .i_inst(inst), .i_inst_vld(vld), .i_br_equal(eq), .i_br_less(lt),
        .o_stall(z_stall), .o_flush(z_flush), .o_pc_sel(z_pc_sel), .o_ex_busy(z_ex_busy),
        .o_ex_vld(z_ex_vld), .o_ex_insn_vld(z_ex_insn_vld), .o_ex_imm_sel(z_ex_imm_sel),
        .o_ex_load_type(z_ex_load_type), .o_ex_slt_sl(z_ex_slt_sl), .o_ex_rd_wren(z_ex_rd_wren),
        .o_ex_wren(z_ex_wren), .o_ex_asel(z_ex_asel), .o_ex_bsel(z_ex_bsel), .o_ex_br_un(z_ex_br_un),
        .o_ex_alu_op(z_ex_alu_op), .o_ex_wb_sel(z_ex_wb_sel), .o_ex_rd(z_ex_rd), .o_ex_rs1(z_ex_rs1),
        .o_ex_rs2(z_ex_rs2)
    );
    int n_chk = 0, n_err = 0;
    logic m_vld = 1'b0;
    logic [31:0] m_inst = '0;
    int m_cnt = 0;
    logic m_stall = 1'b0;
    logic s_stall, s_flush, s_pc, s_busy;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic ctl_t ref_ctl(input logic [31:0] w);
        ctl_t c;
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = w[31:25];
        f3 = w[14:12];
        c = '0;
        c.rd = w[11:7];
        c.rs1 = w[19:15];
        c.rs2 = w[24:20];
        c.wb = 2'b01;
        c.bsel = 1'b1;
        case (w[6:0])
            7'h33: begin
                c.bsel = 1'b0; c.rdw = 1'b1;
                c.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'h01);
                c.alu = (f7 == 7'h01) ? {2'b10, f3} : {1'b0, f7[5], f3};
            end
            7'h13: begin
                c.rdw = 1'b1;
                c.legal = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                c.alu = {1'b0, (f3 == 3'd5) && f7[5], f3};
            end
            7'h03: begin c.legal = (f3 != 3'd3) && (f3 < 3'd6); c.ld = f3; c.rdw = 1'b1; c.wb = 2'b00; end
            7'h23: begin c.legal = f3 < 3'd3; c.st = f3; c.wr = 1'b1; c.imm = 3'd1; end
            7'h63: begin c.legal = (f3 != 3'd2) && (f3 != 3'd3); c.imm = 3'd2; c.asel = 1'b1; c.bun = f3[1]; end
            7'h6F: begin c.legal = 1'b1; c.imm = 3'd3; c.asel = 1'b1; c.rdw = 1'b1; c.wb = 2'b10; end
            7'h67: begin c.legal = (f3 == 3'd0); c.rdw = 1'b1; c.wb = 2'b10; end
            7'h37: begin c.legal = 1'b1; c.imm = 3'd4; c.alu = 5'b01111; c.rdw = 1'b1; end
            7'h17: begin c.legal = 1'b1; c.imm = 3'd5; c.asel = 1'b1; c.rdw = 1'b1; end
            default: c.legal = 1'b0;
        endcase
        if (!c.legal) begin c.rdw = 1'b0; c.wr = 1'b0; end
        return c;
    endfunction
    function automatic logic uses1(input logic [6:0] op);
        return op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63 || op == 7'h67;
    endfunction
    function automatic logic uses2(input logic [6:0] op);
        return op == 7'h33 || op == 7'h23 || op == 7'h63;
    endfunction
    task automatic cycle(input logic [31:0] w, input logic v, input logic e, input logic l, input logic r);
        ctl_t c;
        logic lg, tk, pc, busy, lu, stall;
        logic [2:0] f3;
        @(negedge clk);
        inst = w; vld = v; eq = e; lt = l; rst = r;
        #1;
        c = ref_ctl(m_inst);
        f3 = m_inst[14:12];
        lg = m_vld && c.legal;
        case (f3)
            3'd0: tk = e;
            3'd1: tk = !e;
            3'd4, 3'd6: tk = l;
            3'd5, 3'd7: tk = !l;
            default: tk = 1'b0;
        endcase
        pc = !r && lg && (m_inst[6:0] == 7'h6F || m_inst[6:0] == 7'h67 || (m_inst[6:0] == 7'h63 && tk));
        busy = !r && lg && m_inst[6:0] == 7'h33 && m_inst[31:25] == 7'h01 && f3[2] && m_cnt < DL - 1;
        lu = !r && v && lg && m_inst[6:0] == 7'h03 && c.rd != 5'd0
           && ((uses1(w[6:0]) && w[19:15] == c.rd) || (uses2(w[6:0]) && w[24:20] == c.rd));
        stall = (busy || lu) && !pc;
        chk("pc_sel", o_pc_sel, pc);
        chk("flush", o_flush, pc);
        chk("busy", o_ex_busy, busy);
        chk("stall", o_stall, stall);
        chk("ex_vld", o_ex_vld, m_vld);
        chk("insn_vld", o_ex_insn_vld, lg);
        chk("rd_wren", o_ex_rd_wren, lg && c.rdw);
        chk("wren", o_ex_wren, lg && c.wr);
        chk("regs", {o_ex_rd, o_ex_rs1, o_ex_rs2}, m_vld ? {c.rd, c.rs1, c.rs2} : 15'd0);
        if (!m_vld || lg)
            chk("ctl", {o_ex_imm_sel, o_ex_load_type, o_ex_slt_sl, o_ex_asel, o_ex_bsel, o_ex_br_un, o_ex_alu_op, o_ex_wb_sel},
                m_vld ? {c.imm, c.ld, c.st, c.asel, c.bsel, c.bun, c.alu, c.wb} : 19'd0);
        s_stall = o_stall; s_flush = o_flush; s_pc = o_pc_sel; s_busy = o_ex_busy;
        m_stall = stall;
        @(posedge clk);
        if (r || pc || (!busy && (lu || !v))) begin
            m_vld = 1'b0; m_inst = '0; m_cnt = 0;
        end else if (busy) begin
            m_cnt++;
        end else begin
            m_vld = 1'b1; m_inst = w; m_cnt = 0;
        end
    endtask
    function automatic logic [31:0] rnd_inst();
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        logic [6:0] f7;
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom), 5'($urandom_range(0, 3)),
                ops[$urandom_range(0, 9)]};
    endfunction
    localparam logic [31:0] ADD = 32'h002081B3, LW = 32'h0000A283, ADD6 = 32'h00528333;
    localparam logic [31:0] BEQ = 32'h00000063, NOP = 32'h00000013, DIV = 32'h0220C3B3, ILL = 32'h0000007F;
    initial begin
        logic [31:0] hw;
        logic hv;
        rst = 1'b1; vld = 1'b0; eq = 1'b0; lt = 1'b0; inst = '0;
        repeat (2) cycle(NOP, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 chk("rst_out", {o_ex_vld, o_ex_rd_wren, o_ex_alu_op, o_ex_rd, o_stall, o_ex_busy}, 0);
        cycle(ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("add_out", {o_ex_vld, o_ex_alu_op, o_ex_rd_wren, o_ex_wb_sel, o_ex_rd}, {1'b1, 5'd0, 1'b1, 2'b01, 5'd3});
        chk("add_stall", s_stall, 1'b0);
        cycle(LW, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(ADD6, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_stall", s_stall, 1'b1);
        #1 chk("lu_bubble", o_ex_vld, 1'b0);
        cycle(ADD6, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_stall_end", s_stall, 1'b0);
        #1 chk("lu_add_rd", {o_ex_vld, o_ex_rd}, {1'b1, 5'd6});
        cycle(BEQ, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(NOP, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("beq_taken", {s_pc, s_flush, s_stall}, 3'b110);
        #1 chk("beq_flush_bubble", o_ex_vld, 1'b0);
        cycle(BEQ, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(NOP, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("beq_not_taken", {s_pc, s_flush}, 2'b00);
        #1 chk("beq_nt_next", o_ex_vld, 1'b1);
        cycle(DIV, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("m0_div", {z_ex_vld, z_ex_insn_vld, z_ex_rd_wren}, 3'b100);
        for (int k = 0; k < DL - 1; k++) begin
            cycle(ADD, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("div_busy", {s_busy, s_stall}, 2'b11);
            #1 chk("div_hold", {o_ex_rd, o_ex_alu_op}, {5'd7, 5'b10100});
        end
        cycle(ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("div_done", {s_busy, s_stall}, 2'b00);
        #1 chk("div_next", o_ex_rd, 5'd3);
        cycle(DIV, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_div_comb", {s_busy, s_stall, s_pc, s_flush}, 4'b0000);
        #1 chk("rst_div_regs", {o_ex_vld, o_ex_insn_vld, o_ex_rd_wren, o_ex_alu_op, o_ex_rd}, 0);
        cycle(ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_no_stall", s_stall, 1'b0);
        #1 chk("rst_add", {o_ex_vld, o_ex_rd}, {1'b1, 5'd3});
        cycle(ILL, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("ill_out", {o_ex_vld, o_ex_insn_vld, o_ex_rd_wren, o_ex_wren}, 4'b1000);
        cycle(NOP, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("ill_pc", s_pc, 1'b0);
        hw = NOP; hv = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (!m_stall) begin
                hw = rnd_inst();
                hv = $urandom_range(0, 9) != 0;
            end
            cycle(hw, hv, 1'($urandom), 1'($urandom), $urandom_range(0, 99) == 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
